// File: rtl/clk_div_controller_pkg.sv
// Shared types and helpers for the clock-enable divider controller.
// Holds the FSM state encoding and the divide-ratio clamp.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } cdc_state_t;

    localparam int unsigned MIN_DIV = 2;

    // Ratios below MIN_DIV cannot produce a one-cycle pulse with a gap
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/clk_div_controller_if.sv
// Configuration handshake for the clock-enable divider controller.
// Master offers a divide ratio and tick count; slave accepts when idle.
interface clk_div_controller_if #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic [NUM_W-1:0] cfg_num;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_num,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_num,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_controller_tick_counter.sv
// Period counter for the divider: counts while enabled, clears on demand.
// wrap is high on the enabled cycle where count == limit-1.
module tick_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         wrap
);
    logic [W-1:0] count;

    assign wrap = en && (count == limit - W'(1));

    // Count up, returning to zero on the wrap cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end
endmodule

// File: rtl/clk_div_controller.sv
// Clock-enable tick generator: emits tick every div cycles and clk_out
// toggling on each tick; ends with done after num ticks or on stop.
module clk_div_controller
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int NUM_W     = 8,
    parameter int DEF_DIV   = 20,
    parameter int AUTOSTART = 0
) (
    input  logic                clk,
    input  logic                reset,
    clk_div_controller_if.slave cfg,
    input  logic                stop,
    output logic                tick,
    output logic                clk_out,
    output logic                busy,
    output logic                done,
    output logic [NUM_W-1:0]    tick_cnt
);
    cdc_state_t       state;
    logic [CNT_W-1:0] div_q;
    logic [NUM_W-1:0] num_q;
    logic             auto_q;
    logic             auto_go;
    logic             wrap;
    logic [NUM_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_in;

    assign auto_go   = (AUTOSTART != 0) && !auto_q;
    assign cfg.cfg_ready = (state == IDLE) && !auto_go;
    assign busy      = (state != IDLE);
    assign cnt_nxt   = tick_cnt + NUM_W'(1);
    assign div_in    = CNT_W'(clamp_div(32'(cfg.cfg_div)));

    tick_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != RUN),
        .en    (state == RUN),
        .limit (div_q),
        .wrap  (wrap)
    );

    // Run sequencing with registered tick, clk_out, done and tick_cnt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div_q    <= CNT_W'(MIN_DIV);
            num_q    <= '0;
            auto_q   <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (auto_go) begin
                        auto_q   <= 1'b1;
                        div_q    <= CNT_W'(clamp_div(DEF_DIV));
                        num_q    <= '0;
                        tick_cnt <= '0;
                        state    <= RUN;
                    end else if (cfg.cfg_valid) begin
                        div_q    <= div_in;
                        num_q    <= cfg.cfg_num;
                        tick_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= FINISH;
                    end else if (wrap) begin
                        tick     <= 1'b1;
                        clk_out  <= ~clk_out;
                        tick_cnt <= cnt_nxt;
                        if (num_q != '0 && cnt_nxt == num_q) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    clk_out <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_div_controller.sv
// Scoreboard bench for clk_div_controller: expected tick/done events are
// queued by stimulus and matched by per-instance monitors.
module tb_clk_div_controller;

    typedef struct {
        bit is_done;
        int cyc;
        int co;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst2, stop1, stop2;
    logic tick1, co1, busy1, done1;
    logic tick2, co2, busy2, done2;
    logic [7:0] tc1, tc2;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    exp_t q1[$];
    exp_t q2[$];

    clk_div_controller_if #(.CNT_W(16), .NUM_W(8)) cf1 ();
    clk_div_controller_if #(.CNT_W(16), .NUM_W(8)) cf2 ();

    clk_div_controller #(
        .CNT_W(16), .NUM_W(8), .DEF_DIV(20), .AUTOSTART(0)
    ) dut1 (
        .clk(clk), .reset(rst1), .cfg(cf1), .stop(stop1),
        .tick(tick1), .clk_out(co1), .busy(busy1),
        .done(done1), .tick_cnt(tc1)
    );

    clk_div_controller #(
        .CNT_W(16), .NUM_W(8), .DEF_DIV(20), .AUTOSTART(1)
    ) dut2 (
        .clk(clk), .reset(rst2), .cfg(cf2), .stop(stop2),
        .tick(tick2), .clk_out(co2), .busy(busy2),
        .done(done2), .tick_cnt(tc2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic match(input string tag, input bit d, input exp_t e,
                         input int co, input int cnt);
        chk({tag, " kind"}, int'(d), int'(e.is_done));
        chk({tag, " cycle"}, cyc, e.cyc);
        chk({tag, " clk_out"}, co, e.co);
        chk({tag, " tick_cnt"}, cnt, e.cnt);
    endtask

    // Monitor for the AUTOSTART=0 instance
    always @(negedge clk) begin
        if (rst1 === 1'b1 && (tick1 || done1)) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected event", 1, 0);
            end else begin
                match("dut1", done1, q1.pop_front(), int'(co1), int'(tc1));
            end
        end
    end

    // Monitor for the AUTOSTART=1 instance
    always @(negedge clk) begin
        if (rst2 === 1'b1 && (tick2 || done2)) begin
            if (q2.size() == 0) begin
                chk("dut2 unexpected event", 1, 0);
            end else begin
                match("dut2", done2, q2.pop_front(), int'(co2), int'(tc2));
            end
        end
    end

    function automatic exp_t mk(input bit d, input int c,
                                input int co, input int n);
        exp_t e;
        e.is_done = d;
        e.cyc     = c;
        e.co      = co;
        e.cnt     = n;
        return e;
    endfunction

    // Called at a negedge; returns the acceptance edge number
    task automatic accept1(input int dv, input int num, output int acc);
        int d;
        chk("cfg_ready before accept", int'(cf1.cfg_ready), 1);
        cf1.cfg_valid = 1'b1;
        cf1.cfg_div   = 16'(dv);
        cf1.cfg_num   = 8'(num);
        acc = cyc + 1;
        d = (dv < 2) ? 2 : dv;
        for (int i = 1; i <= num; i++)
            q1.push_back(mk(1'b0, acc + i * d, i % 2, i));
        if (num > 0)
            q1.push_back(mk(1'b1, acc + num * d + 1, 0, num));
        @(posedge clk);
        #1;
        cf1.cfg_valid = 1'b0;
    endtask

    task automatic wait_done1(input int lim);
        bit seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("dut1 done within budget", int'(seen), 1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nt;
        int r;
        bit seen;
        rst1 = 1'b0;
        rst2 = 1'b0;
        stop1 = 1'b0;
        stop2 = 1'b0;
        cf1.cfg_valid = 1'b0;
        cf1.cfg_div = '0;
        cf1.cfg_num = '0;
        cf2.cfg_valid = 1'b0;
        cf2.cfg_div = '0;
        cf2.cfg_num = '0;

        repeat (2) @(negedge clk);
        chk("reset tick", int'(tick1), 0);
        chk("reset clk_out", int'(co1), 0);
        chk("reset done", int'(done1), 0);
        chk("reset busy", int'(busy1), 0);
        chk("reset tick_cnt", int'(tc1), 0);
        rst1 = 1'b1;
        @(negedge clk);
        chk("idle cfg_ready", int'(cf1.cfg_ready), 1);
        chk("idle busy", int'(busy1), 0);
        nt = 0;
        repeat (50) begin
            @(negedge clk);
            if (tick1) nt++;
        end
        chk("idle tick count", nt, 0);

        // div=4, num=3
        accept1(4, 3, acc);
        #1 chk("busy after accept", int'(busy1), 1);
        chk("cfg_ready while run", int'(cf1.cfg_ready), 0);
        wait_done1(40);
        chk("done busy", int'(busy1), 0);
        chk("done cfg_ready", int'(cf1.cfg_ready), 1);
        chk("done tick_cnt", int'(tc1), 3);

        // accepted together with done; div 0 and 1 clamp to 2
        accept1(0, 2, acc);
        wait_done1(40);
        accept1(1, 2, acc);
        wait_done1(40);
        chk("tick_cnt holds", int'(tc1), 2);

        // free-run div=20, stop sampled at acc+96
        accept1(20, 0, acc);
        for (int i = 1; i <= 4; i++)
            q1.push_back(mk(1'b0, acc + 20 * i, i % 2, i));
        q1.push_back(mk(1'b1, acc + 97, 0, 4));
        wait_until(acc + 95);
        stop1 = 1'b1;
        @(negedge clk);
        stop1 = 1'b0;
        wait_done1(10);
        chk("stop tick_cnt", int'(tc1), 4);

        // stop in IDLE has no effect
        stop1 = 1'b1;
        repeat (3) @(negedge clk);
        stop1 = 1'b0;
        chk("idle stop busy", int'(busy1), 0);

        // div=5 free-run, mid-run cfg ignored, then reset
        accept1(5, 0, acc);
        for (int i = 1; i <= 3; i++)
            q1.push_back(mk(1'b0, acc + 5 * i, i % 2, i));
        wait_until(acc + 7);
        cf1.cfg_valid = 1'b1;
        cf1.cfg_div = 16'd7;
        cf1.cfg_num = 8'd1;
        chk("mid-run cfg_ready", int'(cf1.cfg_ready), 0);
        wait_until(acc + 12);
        cf1.cfg_valid = 1'b0;
        wait_until(acc + 17);
        chk("pre-reset tick_cnt", int'(tc1), 3);
        #2 rst1 = 1'b0;
        #1;
        chk("async reset tick_cnt", int'(tc1), 0);
        chk("async reset busy", int'(busy1), 0);
        chk("async reset clk_out", int'(co1), 0);
        chk("async reset done", int'(done1), 0);
        repeat (2) @(negedge clk);
        rst1 = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done1 || busy1) seen = 1'b1;
        end
        chk("no done after reset", int'(seen), 0);

        // AUTOSTART instance
        @(negedge clk);
        rst2 = 1'b1;
        r = cyc + 1;
        q2.push_back(mk(1'b0, r + 20, 1, 1));
        q2.push_back(mk(1'b0, r + 40, 0, 2));
        q2.push_back(mk(1'b1, r + 61, 0, 2));
        @(negedge clk);
        chk("auto busy", int'(busy2), 1);
        chk("auto cfg_ready", int'(cf2.cfg_ready), 0);
        wait_until(r + 59);
        chk("auto cfg_ready late", int'(cf2.cfg_ready), 0);
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("auto done seen", int'(seen), 1);
        chk("auto done cfg_ready", int'(cf2.cfg_ready), 1);
        chk("auto done busy", int'(busy2), 0);
        chk("auto tick_cnt", int'(tc2), 2);

        repeat (5) @(negedge clk);
        chk("q1 drained", q1.size(), 0);
        chk("q2 drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_controller.md
Name: clk_div_controller

Overview:
Programmable controller that sequences the clock-divider function as a clock-enable tick generator. Accepts a configuration (divide ratio, tick count) over a valid/ready handshake. Emits a one-cycle `tick` every `div` clk cycles plus a divided square wave `clk_out`. Finishes with a `done` pulse after `num` ticks or on `stop`. Downstream blocks use `tick`/`clk_out` as enables instead of deriving their own clocks.

Parameters:
- CNT_W, 16, width of divide-ratio counter and `cfg_div`
- NUM_W, 8, width of tick-count field and `tick_cnt`
- DEF_DIV, 20, divide ratio used by autostart
- AUTOSTART, 0, 1 = enter free-run with DEF_DIV immediately after reset release

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller idle, can accept configuration
- cfg_div  in  CNT_W  clk cycles per tick; values 0 and 1 are clamped to 2
- cfg_num  in  NUM_W  ticks to generate; 0 = free-run until `stop`
- stop  in  1  abort the current run
- tick  out  1  one-cycle enable pulse, registered
- clk_out  out  1  toggles on every tick, so its period is 2*div cycles; registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a run ends (count reached or stop)
- tick_cnt  out  NUM_W  ticks issued in the current run

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all counters 0.
  - tick=0, clk_out=0, done=0, busy=0, tick_cnt=0.
  - cfg_ready=1 once reset is released.
  - Reset mid-run aborts the run immediately; no done pulse is generated.
- Autostart: if AUTOSTART=1, the first edge after reset release loads div=DEF_DIV, num=0 and enters RUN. cfg_ready stays 0.
- FSM states IDLE, RUN, FINISH.
- IDLE:
  - cfg_ready=1.
  - On an edge with cfg_valid=1: latch div_q=max(cfg_div,2) and num_q=cfg_num, clear period counter and tick_cnt, go to RUN.
- RUN:
  - Period counter increments on each edge.
  - When counter == div_q-1: counter wraps to 0; the next edge registers tick=1 (one cycle), toggles clk_out and increments tick_cnt.
  - Timing: acceptance at edge 0 gives tick high in the cycles after edges div, 2*div, 3*div, ...
  - When num_q != 0 and the edge registering a tick makes tick_cnt == num_q: go to FINISH.
  - Free-run (num_q=0): tick_cnt wraps modulo 2^NUM_W and the run never self-terminates.
  - stop=1 on any RUN edge: go to FINISH. A tick that would be registered on that same edge is suppressed; stop wins.
  - cfg_valid is ignored (cfg_ready=0). The configuration cannot change mid-run.
- FINISH (one cycle): the next edge sets done=1 for one cycle, forces clk_out=0 and returns to IDLE.
  - cfg_ready=1 in the same cycle that done=1.
  - tick_cnt holds its final value until the next acceptance.
- stop in IDLE or FINISH: no effect.
- cfg_valid together with done: accepted on the following edge as a normal IDLE acceptance.
- All outputs are registered; no combinational path from inputs to outputs except cfg_ready, which is a decode of the state register.

Decomposition:
- Package `clk_div_pkg`:
  - state enum `cdc_state_t` {IDLE, RUN, FINISH}
  - constant MIN_DIV=2
  - clamp function `clamp_div`
- Sub-module `tick_counter`:
  - Period counter with clear/enable.
  - Outputs a `wrap` pulse when count == limit-1.
  - Instantiated once.

Test Plan:
- Reset held 0 for 2 cycles, then released with AUTOSTART=0 -> all outputs 0, cfg_ready=1, no ticks for 50 cycles.
- cfg_div=4, cfg_num=3 accepted at edge 0 ->
  - tick high after edges 4, 8, 12
  - clk_out 1/0/1 at those edges
  - tick_cnt=3
  - done=1 after edge 13 with clk_out=0, busy=0
- cfg_div=20, cfg_num=0 free-run, stop at cycle 95 ->
  - ticks at 20, 40, 60, 80
  - clk_out period 40
  - no tick at 100
  - done at cycle 97
  - tick_cnt=4
- cfg_div=0 and cfg_div=1 -> both behave as div=2: tick every 2nd cycle, clk_out period 4.
- Mid-run cfg_valid with cfg_div=7 while running div=5 -> ignored, spacing stays 5; reset asserted mid-run -> outputs 0 immediately, no done pulse.
- AUTOSTART=1 -> ticks every 20 cycles after reset release, cfg_ready=0 until stop; the completion edge coinciding with stop -> that tick is suppressed and done is still produced.
